// File: rtl/mips_regfile_scoreboard_pkg.sv
// Shared definitions for the decode-stage register file with pending-write scoreboard.
//   Data_Control_Control_T : clock/reset bundle driven into the top module.
//   word_t / reg_addr_t    : register word and register address at default widths.
//   pend_cnt_t             : per-register pending-write counter at default width.
//   RegZero                : index of the hardwired-zero register.
package mips_regfile_scoreboard_pkg;

  localparam int unsigned DataWDef = 32;
  localparam int unsigned AddrWDef = 5;
  localparam int unsigned PendWDef = 2;

  // Register $0 reads as zero and ignores writes, reserves and releases.
  localparam int unsigned RegZero = 0;

  typedef logic [DataWDef-1:0] word_t;
  typedef logic [AddrWDef-1:0] reg_addr_t;
  typedef logic [PendWDef-1:0] pend_cnt_t;

  // One clock, synchronous active-high reset.
  typedef struct packed {
    logic clk;
    logic rst;
  } Data_Control_Control_T;

endpackage

// File: rtl/mips_regfile_pending_counter.sv
// Saturating up/down counter tracking outstanding writes to one register.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset, clears the count
//   inc_i   : reserve (issue) for this register
//   dec_i   : release (writeback) for this register
//   count_o : current number of outstanding writes
//   err_o   : pulses when an increment hits max or a decrement hits zero
//             (the count holds in both cases)
module mips_regfile_pending_counter #(
  parameter int unsigned PEND_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inc_i,
  input  logic              dec_i,
  output logic [PEND_W-1:0] count_o,
  output logic              err_o
);

  localparam logic [PEND_W-1:0] CntMax = '1;

  logic [PEND_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    err_o   = 1'b0;
    // Reserve and release together cancel out and can never over/underflow.
    unique case ({inc_i, dec_i})
      2'b10: begin
        if (count_q == CntMax) err_o = 1'b1;
        else                   count_d = count_q + 1'b1;
      end
      2'b01: begin
        if (count_q == '0) err_o = 1'b1;
        else               count_d = count_q - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/mips_regfile_scoreboard.sv
// N-read / 1-write MIPS register file with write-first bypass, hardwired $0 and a
// per-register pending-write scoreboard used by the hazard unit.
//   ctrl      : clock and synchronous active-high reset bundle
//   rdAddr    : READ_PORTS packed read addresses (port k at [k*ADDR_W +: ADDR_W])
//   rdData    : READ_PORTS packed read data, post-bypass, zero during reset
//   rdBusy    : port k's register still has writes outstanding after this cycle's release
//   portEq    : post-bypass read data of port 0 equals port 1 (branch compare)
//   wrEnable/wrAddr/wrData : writeback-stage write
//   rsvEnable/rsvAddr      : issue reserves a destination register
//   relEnable/relAddr      : writeback releases a destination register
//   sbError   : sticky scoreboard over/underflow flag, cleared only by reset
module mips_regfile_scoreboard
  import mips_regfile_scoreboard_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned READ_PORTS = 2,
  parameter int unsigned PEND_W     = 2
) (
  input  Data_Control_Control_T          ctrl,
  input  logic [READ_PORTS*ADDR_W-1:0]   rdAddr,
  output logic [READ_PORTS*DATA_W-1:0]   rdData,
  output logic [READ_PORTS-1:0]          rdBusy,
  output logic                           portEq,
  input  logic                           wrEnable,
  input  logic [ADDR_W-1:0]              wrAddr,
  input  logic [DATA_W-1:0]              wrData,
  input  logic                           rsvEnable,
  input  logic [ADDR_W-1:0]              rsvAddr,
  input  logic                           relEnable,
  input  logic [ADDR_W-1:0]              relAddr,
  output logic                           sbError
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] AddrZero = ADDR_W'(RegZero);

  logic clk;
  logic rst;
  assign clk = ctrl.clk;
  assign rst = ctrl.rst;

  // ---------------------------------------------------------------------------
  // Register storage
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] regs_q [NumRegs];
  logic [DATA_W-1:0] regs_d [NumRegs];

  always_comb begin
    regs_d = regs_q;
    if (wrEnable && (wrAddr != AddrZero)) regs_d[wrAddr] = wrData;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending-write scoreboard; register 0 has no counter and never errors.
  // ---------------------------------------------------------------------------
  logic [PEND_W-1:0] pend_cnt [NumRegs];
  logic [NumRegs-1:0] pend_err;

  assign pend_cnt[0] = '0;
  assign pend_err[0] = 1'b0;

  for (genvar r = 1; r < NumRegs; r++) begin : g_pend
    mips_regfile_pending_counter #(
      .PEND_W (PEND_W)
    ) u_cnt (
      .clk_i   (clk),
      .rst_i   (rst),
      .inc_i   (rsvEnable && (rsvAddr == ADDR_W'(r))),
      .dec_i   (relEnable && (relAddr == ADDR_W'(r))),
      .count_o (pend_cnt[r]),
      .err_o   (pend_err[r])
    );
  end

  logic sb_error_q, sb_error_d;

  always_comb begin
    sb_error_d = sb_error_q | (|pend_err);
  end

  always_ff @(posedge clk) begin
    if (rst) sb_error_q <= 1'b0;
    else     sb_error_q <= sb_error_d;
  end

  assign sbError = sb_error_q;

  // ---------------------------------------------------------------------------
  // Read ports: storage, write-first bypass, $0 forcing, busy with release bypass
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_word;
  logic [PEND_W-1:0] rd_cnt;
  logic              rd_rel_hit;
  logic              rd_busy;

  always_comb begin
    rdData     = '0;
    rdBusy     = '0;
    rd_addr    = '0;
    rd_word    = '0;
    rd_cnt     = '0;
    rd_rel_hit = 1'b0;
    rd_busy    = 1'b0;
    for (int k = 0; k < READ_PORTS; k++) begin
      rd_addr = rdAddr[k*ADDR_W +: ADDR_W];

      rd_word = regs_q[rd_addr];
      if (wrEnable && (wrAddr == rd_addr)) rd_word = wrData;
      if (rst || (rd_addr == AddrZero))    rd_word = '0;
      rdData[k*DATA_W +: DATA_W] = rd_word;

      // A same-cycle release unblocks the consumer, mirroring the data bypass.
      // A release of an already-empty counter is an underflow and leaves it idle.
      rd_cnt     = pend_cnt[rd_addr];
      rd_rel_hit = relEnable && (relAddr == rd_addr);
      rd_busy    = rd_rel_hit ? (rd_cnt > PEND_W'(1)) : (rd_cnt != '0);
      rdBusy[k]  = rd_busy && !rst;
    end
  end

  assign portEq = (rdData[0 +: DATA_W] == rdData[DATA_W +: DATA_W]);

endmodule

// File: tb/tb_mips_regfile_scoreboard.sv
// Bench for mips_regfile_scoreboard: directed vector table followed by randomized
// traffic checked against a behavioural model of the register file and scoreboard.
module tb_mips_regfile_scoreboard;
  import mips_regfile_scoreboard_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned RP = 3;
  localparam int unsigned PW = 2;
  localparam int          NR = 32;
  localparam int          PMAX = 3;

  logic clk = 1'b0;
  logic rst;
  Data_Control_Control_T ctrl;
  logic [RP*AW-1:0] rd_addr;
  logic [RP*DW-1:0] rd_data;
  logic [RP-1:0]    rd_busy;
  logic             port_eq;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             rsv_en;
  logic [AW-1:0]    rsv_addr;
  logic             rel_en;
  logic [AW-1:0]    rel_addr;
  logic             sb_error;

  always #5 clk = ~clk;
  assign ctrl = '{clk: clk, rst: rst};

  mips_regfile_scoreboard #(
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .READ_PORTS (RP),
    .PEND_W     (PW)
  ) dut (
    .ctrl      (ctrl),
    .rdAddr    (rd_addr),
    .rdData    (rd_data),
    .rdBusy    (rd_busy),
    .portEq    (port_eq),
    .wrEnable  (wr_en),
    .wrAddr    (wr_addr),
    .wrData    (wr_data),
    .rsvEnable (rsv_en),
    .rsvAddr   (rsv_addr),
    .relEnable (rel_en),
    .relAddr   (rel_addr),
    .sbError   (sb_error)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [NR];
  int          m_pend [NR];
  bit          m_err;
  int          cur_a [RP];

  function automatic logic [31:0] m_data(input int a);
    if (rst || a == 0) return 32'h0;
    if (wr_en && int'(wr_addr) == a) return wr_data;
    return m_mem[a];
  endfunction

  function automatic bit m_busy(input int a);
    int p;
    if (rst) return 1'b0;
    p = m_pend[a];
    if (rel_en && int'(rel_addr) == a && p > 0) p--;
    return p != 0;
  endfunction

  task automatic m_tick();
    bit inc, dec;
    if (rst) begin
      for (int r = 0; r < NR; r++) begin
        m_mem[r]  = 32'h0;
        m_pend[r] = 0;
      end
      m_err = 1'b0;
    end else begin
      if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
      for (int r = 1; r < NR; r++) begin
        inc = rsv_en && int'(rsv_addr) == r;
        dec = rel_en && int'(rel_addr) == r;
        if (inc && !dec) begin
          if (m_pend[r] == PMAX) m_err = 1'b1;
          else m_pend[r]++;
        end else if (dec && !inc) begin
          if (m_pend[r] == 0) m_err = 1'b1;
          else m_pend[r]--;
        end
      end
    end
  endtask

  task automatic drive(input bit r, input bit we, input int wa, input logic [31:0] wd,
                       input bit rsv, input int rsva, input bit rel, input int rela,
                       input int a0, input int a1, input int a2);
    rst      = r;
    wr_en    = we;
    wr_addr  = AW'(wa);
    wr_data  = wd;
    rsv_en   = rsv;
    rsv_addr = AW'(rsva);
    rel_en   = rel;
    rel_addr = AW'(rela);
    rd_addr  = {AW'(a2), AW'(a1), AW'(a0)};
    cur_a[0] = a0;
    cur_a[1] = a1;
    cur_a[2] = a2;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rst;
    bit          we;
    int          wa;
    logic [31:0] wd;
    bit          rsv;
    int          rsva;
    bit          rel;
    int          rela;
    int          a0;
    int          a1;
    int          a2;
    logic [31:0] e_d0;
    logic [31:0] e_d2;
    logic [2:0]  e_busy;
    bit          e_eq;
    bit          e_err;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // rst we wa wd rsv rsva rel rela a0 a1 a2 | d0 d2 busy eq err
    tbl.push_back('{1, 1, 5, 32'hAAAA,     0, 0, 0, 0, 5, 5, 5, 32'h0, 32'h0, 3'b000, 1, 0});
    tbl.push_back('{0, 0, 0, 32'h0,        0, 0, 0, 0, 5, 0, 31, 32'h0, 32'h0, 3'b000, 1, 0});
    tbl.push_back('{0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 5, 0, 5,
                    32'hDEADBEEF, 32'hDEADBEEF, 3'b000, 0, 0});
    tbl.push_back('{0, 0, 0, 32'h0,        0, 0, 0, 0, 5, 5, 0, 32'hDEADBEEF, 32'h0, 3'b000, 1, 0});
    tbl.push_back('{0, 1, 0, 32'h1234,     0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 3'b000, 1, 0});
    tbl.push_back('{0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 3'b000, 1, 0});
    // r7: reserve twice, release twice
    tbl.push_back('{0, 0, 0, 32'h0,        1, 7, 0, 0, 7, 7, 7, 32'h0, 32'h0, 3'b000, 1, 0});
    tbl.push_back('{0, 0, 0, 32'h0,        1, 7, 0, 0, 7, 7, 7, 32'h0, 32'h0, 3'b111, 1, 0});
    tbl.push_back('{0, 0, 0, 32'h0,        0, 0, 1, 7, 7, 7, 7, 32'h0, 32'h0, 3'b111, 1, 0});
    tbl.push_back('{0, 0, 0, 32'h0,        0, 0, 1, 7, 0, 7, 0, 32'h0, 32'h0, 3'b000, 1, 0});
    tbl.push_back('{0, 0, 0, 32'h0,        0, 0, 0, 0, 7, 7, 7, 32'h0, 32'h0, 3'b000, 1, 0});
    // r9: counter 1, simultaneous reserve+release keeps it at 1
    tbl.push_back('{0, 0, 0, 32'h0,        1, 9, 0, 0, 9, 9, 9, 32'h0, 32'h0, 3'b000, 1, 0});
    tbl.push_back('{0, 0, 0, 32'h0,        1, 9, 1, 9, 9, 9, 9, 32'h0, 32'h0, 3'b000, 1, 0});
    tbl.push_back('{0, 0, 0, 32'h0,        0, 0, 0, 0, 9, 9, 9, 32'h0, 32'h0, 3'b111, 1, 0});
    tbl.push_back('{0, 0, 0, 32'h0,        0, 0, 1, 9, 9, 9, 9, 32'h0, 32'h0, 3'b000, 1, 0});
    // r3 overflow
    tbl.push_back('{0, 0, 0, 32'h0,        1, 3, 0, 0, 3, 0, 0, 32'h0, 32'h0, 3'b000, 1, 0});
    tbl.push_back('{0, 0, 0, 32'h0,        1, 3, 0, 0, 3, 0, 0, 32'h0, 32'h0, 3'b001, 1, 0});
    tbl.push_back('{0, 0, 0, 32'h0,        1, 3, 0, 0, 3, 0, 0, 32'h0, 32'h0, 3'b001, 1, 0});
    tbl.push_back('{0, 0, 0, 32'h0,        1, 3, 0, 0, 3, 0, 0, 32'h0, 32'h0, 3'b001, 1, 0});
    tbl.push_back('{0, 0, 0, 32'h0,        0, 0, 0, 0, 3, 3, 3, 32'h0, 32'h0, 3'b111, 1, 1});
    // reset, then r4 underflow
    tbl.push_back('{1, 0, 0, 32'h0,        0, 0, 0, 0, 3, 3, 3, 32'h0, 32'h0, 3'b000, 1, 1});
    tbl.push_back('{0, 0, 0, 32'h0,        0, 0, 1, 4, 4, 4, 4, 32'h0, 32'h0, 3'b000, 1, 0});
    tbl.push_back('{0, 0, 0, 32'h0,        0, 0, 0, 0, 4, 3, 3, 32'h0, 32'h0, 3'b000, 1, 1});
    // three ports: r1=r2=0x55, r3=0x66
    tbl.push_back('{0, 1, 1, 32'h55,       0, 0, 0, 0, 1, 2, 3, 32'h55, 32'h0, 3'b000, 0, 1});
    tbl.push_back('{0, 1, 2, 32'h55,       0, 0, 0, 0, 1, 2, 3, 32'h55, 32'h0, 3'b000, 1, 1});
    tbl.push_back('{0, 1, 3, 32'h66,       0, 0, 0, 0, 1, 2, 3, 32'h55, 32'h66, 3'b000, 1, 1});
    tbl.push_back('{0, 0, 0, 32'h0,        0, 0, 0, 0, 1, 2, 3, 32'h55, 32'h66, 3'b000, 1, 1});
    // mid-sequence reset drops the write, reservation and stored data
    tbl.push_back('{1, 1, 6, 32'h77,       1, 5, 0, 0, 1, 2, 6, 32'h0, 32'h0, 3'b000, 1, 1});
    tbl.push_back('{0, 0, 0, 32'h0,        0, 0, 0, 0, 1, 2, 6, 32'h0, 32'h0, 3'b000, 1, 0});
    tbl.push_back('{0, 0, 0, 32'h0,        0, 0, 1, 5, 5, 5, 5, 32'h0, 32'h0, 3'b000, 1, 0});
    tbl.push_back('{0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 3'b000, 1, 1});
  end

  // ---------------- stimulus ----------------
  initial begin
    vec_t v;
    int   a;
    drive(1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    for (int r = 0; r < NR; r++) begin
      m_mem[r]  = 32'h0;
      m_pend[r] = 0;
    end
    m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      drive(v.rst, v.we, v.wa, v.wd, v.rsv, v.rsva, v.rel, v.rela, v.a0, v.a1, v.a2);
      #1;
      check($sformatf("v%0d.d0", i), rd_data[0 +: DW], v.e_d0);
      check($sformatf("v%0d.d2", i), rd_data[2*DW +: DW], v.e_d2);
      check($sformatf("v%0d.busy", i), 32'(rd_busy), 32'(v.e_busy));
      check($sformatf("v%0d.eq", i), 32'(port_eq), 32'(v.e_eq));
      check($sformatf("v%0d.err", i), 32'(sb_error), 32'(v.e_err));
      m_tick();
      @(posedge clk);
      #1;
    end

    // Randomized traffic on a small address window to provoke hazards.
    for (int c = 0; c < 3000; c++) begin
      int ad [7];
      for (int j = 0; j < 7; j++) begin
        ad[j] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, NR - 1))
                                            : int'($urandom_range(0, 7));
      end
      drive($urandom_range(0, 149) == 0, $urandom_range(0, 1) == 1, ad[0], $urandom,
            $urandom_range(0, 2) == 0, ad[1], $urandom_range(0, 2) == 0, ad[2],
            ad[3], ad[4], ad[5]);
      #1;
      for (int p = 0; p < RP; p++) begin
        a = cur_a[p];
        check($sformatf("rnd%0d.d%0d", c, p), rd_data[p*DW +: DW], m_data(a));
        check($sformatf("rnd%0d.busy%0d", c, p), 32'(rd_busy[p]), 32'(m_busy(a)));
      end
      check($sformatf("rnd%0d.eq", c), 32'(port_eq), 32'(m_data(cur_a[0]) == m_data(cur_a[1])));
      check($sformatf("rnd%0d.err", c), 32'(sb_error), 32'(m_err));
      m_tick();
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
